// File: rtl/pfa32_sched.sv
// rtl/pfa32_sched.sv - two-requester round-robin front end for a shared pipelined fp32 adder (optional PFA32_SCHED_STATS_EN issue counters)
module pfa32_sched #(
  parameter int LAT   = 3,   // adder latency, operand capture to Sum valid; must be >= 1
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  input  logic [31:0]      req0_a,
  input  logic [31:0]      req0_b,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [31:0]      req1_a,
  input  logic [31:0]      req1_b,
  output logic             req1_ready,
  output logic [31:0]      add_a,
  output logic [31:0]      add_b,
  input  logic [31:0]      add_sum,
  output logic             res_valid,
  output logic             res_id,
  output logic [31:0]      res_sum,
  output logic             busy,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1
);

  logic           grant0;
  logic           grant1;
  logic           accept;
  logic           win_id;
  logic           last;
  logic [LAT:0]   tag_valid;
  logic [LAT:0]   tag_id;

  // Round-robin grant: a lone requester always wins, contention goes to the one not served last.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (req0_valid && req1_valid) begin
      if (last) grant0 = 1'b1;
      else      grant1 = 1'b1;
    end else if (req0_valid) begin
      grant0 = 1'b1;
    end else if (req1_valid) begin
      grant1 = 1'b1;
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign accept     = grant0 | grant1;
  assign win_id     = grant1;

  // Operand registers feeding the adder; they hold when nothing is accepted.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      add_a <= 32'h0;
      add_b <= 32'h0;
    end else if (accept) begin
      add_a <= win_id ? req1_a : req0_a;
      add_b <= win_id ? req1_b : req0_b;
    end
  end

  // Last-served pointer; resets to 1 so requester 0 wins the first contention.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last <= 1'b1;
    end else if (accept) begin
      last <= win_id;
    end
  end

  // Ownership tags travel alongside the adder pipeline so each sum finds its owner.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tag_valid <= '0;
      tag_id    <= '0;
    end else begin
      tag_valid <= {tag_valid[LAT-1:0], accept};
      tag_id    <= {tag_id[LAT-1:0], win_id};
    end
  end

  // Result registers: capture the adder sum only when the aligned tag is live.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      res_valid <= 1'b0;
      res_id    <= 1'b0;
      res_sum   <= 32'h0;
    end else begin
      res_valid <= tag_valid[LAT];
      res_id    <= tag_id[LAT];
      if (tag_valid[LAT]) begin
        res_sum <= add_sum;
      end
    end
  end

  assign busy = (|tag_valid) | res_valid;

`ifdef PFA32_SCHED_STATS_EN
  logic [CNT_W-1:0] cnt0_q;
  logic [CNT_W-1:0] cnt1_q;

  // Saturating per-requester accept counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      if (grant0 && (cnt0_q != '1)) cnt0_q <= cnt0_q + CNT_W'(1);
      if (grant1 && (cnt1_q != '1)) cnt1_q <= cnt1_q + CNT_W'(1);
    end
  end

  assign cnt0 = cnt0_q;
  assign cnt1 = cnt1_q;
`else
  assign cnt0 = '0;
  assign cnt1 = '0;
`endif

endmodule

// File: tb/tb_pfa32_sched.sv
// tb/tb_pfa32_sched.sv - self-checking bench for pfa32_sched with a transaction-level model
module tb_pfa32_sched;
  localparam int LAT   = 3;
  localparam int CNT_W = 2;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk;
  logic             reset;
  logic             req0_valid, req1_valid;
  logic [31:0]      req0_a, req0_b, req1_a, req1_b;
  logic             req0_ready, req1_ready;
  logic [31:0]      add_a, add_b, add_sum;
  logic             res_valid, res_id;
  logic [31:0]      res_sum;
  logic             busy;
  logic [CNT_W-1:0] cnt0, cnt1;

  int total = 0;
  int bad   = 0;

  pfa32_sched #(.LAT(LAT), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
    .add_a(add_a), .add_b(add_b), .add_sum(add_sum),
    .res_valid(res_valid), .res_id(res_id), .res_sum(res_sum),
    .busy(busy), .cnt0(cnt0), .cnt1(cnt1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // fp32 <-> real conversion for normal numbers and zero, enough for the adder model
  function automatic real sp2real(input logic [31:0] x);
    logic [63:0] d;
    logic [10:0] e;
    if (x[30:0] == 31'd0) return 0.0;
    e = {3'b000, x[30:23]} + 11'd896;
    d = {x[31], e, x[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] real2sp(input real r);
    logic [63:0] d;
    logic [10:0] e;
    d = $realtobits(r);
    if (d[62:0] == 63'd0) return {d[63], 31'd0};
    e = d[62:52] - 11'd896;
    return {d[63], e[7:0], d[51:29]};
  endfunction

  function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
    return real2sp(sp2real(a) + sp2real(b));
  endfunction

  // adder stand-in: sum of operands captured at edge k is presented after edge k+LAT-1
  logic [31:0] stg [LAT];
  always @(posedge clk) begin
    stg[0] <= fadd(add_a, add_b);
    for (int i = 1; i < LAT; i++) stg[i] <= stg[i-1];
  end
  assign add_sum = stg[LAT-1];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] rr_grant(input logic v0, input logic v1, input logic lst);
    if (v0 && v1) return lst ? 2'b01 : 2'b10;
    if (v0) return 2'b01;
    if (v1) return 2'b10;
    return 2'b00;
  endfunction

  // transaction model: each accept becomes a queue entry due LAT+1 edges later
  typedef struct {
    logic        id;
    logic [31:0] a;
    logic [31:0] b;
    int          due;
  } txn_t;

  txn_t        q[$];
  int          cyc = 0;
  logic        m_last = 1'b1;
  logic [31:0] m_add_a = 32'h0, m_add_b = 32'h0, m_res_sum = 32'h0;
  logic        m_res_valid = 1'b0, m_res_id = 1'b0;
  int          m_cnt0 = 0, m_cnt1 = 0;

  always @(posedge clk) begin
    logic [1:0] g;
    txn_t t;
    cyc++;
    if (!reset) begin
      q.delete();
      m_last = 1'b1;
      m_add_a = 32'h0; m_add_b = 32'h0; m_res_sum = 32'h0;
      m_res_valid = 1'b0; m_res_id = 1'b0;
      m_cnt0 = 0; m_cnt1 = 0;
    end else begin
      g = rr_grant(req0_valid, req1_valid, m_last);
      m_res_valid = 1'b0;
      if (q.size() > 0 && q[0].due == cyc) begin
        t = q.pop_front();
        m_res_valid = 1'b1;
        m_res_id = t.id;
        m_res_sum = fadd(t.a, t.b);
      end
      if (g != 2'b00) begin
        t.id  = g[1];
        t.a   = g[1] ? req1_a : req0_a;
        t.b   = g[1] ? req1_b : req0_b;
        t.due = cyc + LAT + 1;
        q.push_back(t);
        m_add_a = t.a;
        m_add_b = t.b;
        m_last  = t.id;
`ifdef PFA32_SCHED_STATS_EN
        if (!t.id && m_cnt0 < CMAX) m_cnt0++;
        if (t.id && m_cnt1 < CMAX) m_cnt1++;
`endif
      end
    end
  end

  // compare process on the falling edge
  always @(negedge clk) begin
    logic [1:0] g;
    if (!reset) begin
      g = rr_grant(req0_valid, req1_valid, 1'b1);
      chk("rst_add_a", add_a, 32'h0);
      chk("rst_add_b", add_b, 32'h0);
      chk("rst_res_valid", 32'(res_valid), 32'h0);
      chk("rst_res_id", 32'(res_id), 32'h0);
      chk("rst_res_sum", res_sum, 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_cnt0", 32'(cnt0), 32'h0);
      chk("rst_cnt1", 32'(cnt1), 32'h0);
    end else begin
      g = rr_grant(req0_valid, req1_valid, m_last);
      chk("add_a", add_a, m_add_a);
      chk("add_b", add_b, m_add_b);
      chk("res_valid", 32'(res_valid), 32'(m_res_valid));
      chk("res_sum", res_sum, m_res_sum);
      if (m_res_valid) chk("res_id", 32'(res_id), 32'(m_res_id));
      chk("busy", 32'(busy), 32'((q.size() > 0) || m_res_valid));
      chk("cnt0", 32'(cnt0), 32'(m_cnt0));
      chk("cnt1", 32'(cnt1), 32'(m_cnt1));
    end
    chk("req0_ready", 32'(req0_ready), 32'(g[0]));
    chk("req1_ready", 32'(req1_ready), 32'(g[1]));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_c[5];
`ifdef PFA32_SCHED_STATS_EN
    exp_c = '{1, 2, 3, 3, 3};
`else
    exp_c = '{0, 0, 0, 0, 0};
`endif
    reset = 1'b0;
    req0_valid = 1'b0; req0_a = 32'h0; req0_b = 32'h0;
    req1_valid = 1'b0; req1_a = 32'h0; req1_b = 32'h0;
    idle(2);
    chk("lit_reset_add_a", add_a, 32'h0);
    chk("lit_reset_busy", 32'(busy), 32'h0);
    chk("lit_reset_res_valid", 32'(res_valid), 32'h0);
    reset = 1'b1;
    idle(1);

    // single requester
    req0_valid = 1'b1; req0_a = 32'h3F800000; req0_b = 32'h40000000;
    tick();
    req0_valid = 1'b0;
    chk("lit_single_add_a", add_a, 32'h3F800000);
    idle(3);
    chk("lit_single_early", 32'(res_valid), 32'h0);
    tick();
    chk("lit_single_valid", 32'(res_valid), 32'h1);
    chk("lit_single_id", 32'(res_id), 32'h0);
    chk("lit_single_sum", res_sum, 32'h40400000);
    tick();
    chk("lit_single_pulse", 32'(res_valid), 32'h0);
    chk("lit_single_busy", 32'(busy), 32'h0);
    idle(2);

    // streaming from requester 1
    req1_valid = 1'b1; req1_a = 32'h00000000; req1_b = 32'h3F800000;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("lit_stream_busy", 32'(busy), 32'h1);
      if (i >= 4) begin
        chk("lit_stream_valid", 32'(res_valid), 32'h1);
        chk("lit_stream_sum", res_sum, 32'h3F800000);
        chk("lit_stream_id", 32'(res_id), 32'h1);
      end
    end
    req1_valid = 1'b0;
    for (int j = 8; j < 12; j++) begin
      tick();
      chk("lit_stream_valid", 32'(res_valid), 32'h1);
      chk("lit_stream_busy", 32'(busy), 32'h1);
    end
    tick();
    chk("lit_stream_end_valid", 32'(res_valid), 32'h0);
    chk("lit_stream_end_busy", 32'(busy), 32'h0);
    idle(2);

    // contention: last served was requester 1, so grants run 0,1,0,1
    req0_valid = 1'b1; req0_a = 32'h3E800000; req0_b = 32'h3E800000;
    req1_valid = 1'b1; req1_a = 32'h4F000000; req1_b = 32'h4F000000;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("lit_cont_ready0", 32'(req0_ready), 32'((i % 2) == 0));
      chk("lit_cont_ready1", 32'(req1_ready), 32'((i % 2) == 1));
      tick();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("lit_cont_valid", 32'(res_valid), 32'h1);
      chk("lit_cont_id", 32'(res_id), 32'(k % 2));
      chk("lit_cont_sum", res_sum, ((k % 2) == 1) ? 32'h4F800000 : 32'h3F000000);
    end
    idle(3);

    // reset mid-flight
    req1_valid = 1'b1; req1_a = 32'h3F800000; req1_b = 32'h3F800000;
    idle(2);
    req1_valid = 1'b0;
    reset = 1'b0;
    #1;
    chk("lit_mid_add_a", add_a, 32'h0);
    chk("lit_mid_add_b", add_b, 32'h0);
    chk("lit_mid_busy", 32'(busy), 32'h0);
    tick();
    reset = 1'b1;
    for (int i = 0; i < 7; i++) begin
      tick();
      chk("lit_mid_no_result", 32'(res_valid), 32'h0);
    end
    req0_valid = 1'b1; req0_a = 32'h40000000; req0_b = 32'h40000000;
    req1_valid = 1'b1; req1_a = 32'h3F800000; req1_b = 32'h3F800000;
    #1;
    chk("lit_mid_grant0", 32'(req0_ready), 32'h1);
    chk("lit_mid_grant1", 32'(req1_ready), 32'h0);
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    idle(6);

    // stats
    reset = 1'b0;
    tick();
    reset = 1'b1;
    req0_valid = 1'b1; req0_a = 32'h3F800000; req0_b = 32'h3F800000;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("lit_stats_cnt0", 32'(cnt0), 32'(exp_c[k]));
      chk("lit_stats_cnt1", 32'(cnt1), 32'h0);
    end
    req0_valid = 1'b0;
    idle(8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pfa32_sched.md
# pfa32_sched

Two-requester round-robin scheduler that shares a single pipelined 32-bit floating-point adder (`pfa32pipe`) between two clients. It accepts one operand pair per cycle through a valid/ready handshake and drives the adder's operand inputs. It tracks which requester owns each in-flight operation in a tag pipeline aligned to the adder latency, then returns the registered sum tagged with the owner's ID. It sits directly in front of the adder instance, and both clients see a fixed-latency shared add service.

## Interface
- `LAT`, 3: adder pipeline latency in cycles, from operand-capture edge to `Sum` valid. Must be ≥ 1.
- `CNT_W`, 16: width of the per-requester issue counters.

- `clk`  in  1  rising-edge clock shared with the adder.
- `reset`  in  1  asynchronous, active-low reset.
- `req0_valid`  in  1  requester 0 has an operand pair.
- `req0_a`, `req0_b`  in  32  requester 0 operands (IEEE-754 single).
- `req0_ready`  out  1  requester 0 accepted this cycle.
- `req1_valid`, `req1_a`, `req1_b`, `req1_ready`: same as requester 0, for requester 1.
- `add_a`, `add_b`  out  32  registered operands to the adder `A`/`B`.
- `add_sum`  in  32  adder `Sum`.
- `res_valid`  out  1  one-cycle pulse, `res_sum` valid.
- `res_id`  out  1  owner of the current result (0/1).
- `res_sum`  out  32  registered result.
- `busy`  out  1  high while any tag-pipe entry is valid.
- `cnt0`, `cnt1`  out  CNT_W  issue counters (see Configuration).

## Operation
- Arbitration is combinational from the valid inputs and the `last` pointer.
  - Only one valid: grant it.
  - Both valid: grant the requester ≠ `last`.
  - Neither valid: no grant.
- `reqN_ready` = grant N. At most one ready is high per cycle.
- Accept = `reqN_valid & reqN_ready` at a rising edge. On accept:
  - `add_a`/`add_b` load the winner's operands.
  - `last` ← winner ID.
  - Tag entry 0 ← {valid=1, id=winner}.
- No accept: `add_a`/`add_b` hold their value, tag entry 0 ← valid=0, and `last` is unchanged.
- Tag pipe: LAT+1 entries of {valid, id}, shifted every cycle. The final entry drives the result registers:
  - `res_valid` ← entry[LAT].valid
  - `res_id` ← entry[LAT].id
  - `res_sum` ← `add_sum` when entry[LAT].valid, otherwise held.
- Results have no backpressure; clients must sink `res_valid` pulses unconditionally.
- Requester operand values are not inspected; all arithmetic, rounding and special cases belong to the adder.
- `busy` = OR of all tag-entry valid bits and `res_valid`.

## Timing
- Throughput: one accept per cycle, no stall.
- Latency: accept at edge E0 → `add_a`/`add_b` valid after E0 → `add_sum` valid after E0+LAT → `res_valid` high for one cycle after edge E0+LAT+1.
- Results return in issue order. Back-to-back accepts produce back-to-back `res_valid` pulses.
- Reset (`reset`=0, asynchronous) forces:
  - all outputs to 0: `add_a`, `add_b`, `res_valid`, `res_id`, `res_sum`, `busy`, `cnt0`, `cnt1`;
  - all tag entries to valid=0;
  - `last` to 1, so requester 0 wins the first contention.
- Reset asserted mid-operation discards all in-flight tags. No `res_valid` appears for operations accepted before reset, even if the adder later emits sums.
- Release of reset is synchronous to `clk` at the system level. The first accept can occur on the first rising edge with `reset`=1.
- `reqN_ready` may depend combinationally on `reqN_valid`. Requesters must not make `valid` depend on `ready`.

## Configuration
- `PFA32_SCHED_STATS_EN` defined:
  - `cnt0`/`cnt1` increment by 1 on each accept from requester 0/1.
  - Counters saturate at 2^CNT_W−1 and clear on reset.
- `PFA32_SCHED_STATS_EN` undefined: `cnt0`/`cnt1` are tied to 0 and no counter flops are built.

## Test plan
- **Single requester:** req0 {3F800000, 40000000} for one cycle, LAT=3 → `res_valid` 4 cycles after the accept edge, with `res_id`=0 and `res_sum`=40400000.
- **Contention:** both valid for 4 cycles.
  - Grants alternate 0,1,0,1.
  - req0 {3E800000, 3E800000} → `res_sum`=3F000000, `res_id`=0.
  - req1 {4F000000, 4F000000} → `res_sum`=4F800000, `res_id`=1.
  - Results return in grant order.
- **Streaming:** req1 only, valid 8 consecutive cycles with {00000000, 3F800000} → 8 consecutive `res_valid` pulses with `res_sum`=3F800000 and `res_id`=1. `busy` stays high throughout and falls the cycle after the last pulse.
- **Reset mid-flight:** 2 accepts, then `reset`=0 for one cycle before the first result → no `res_valid`, `busy`=0, `add_a`=`add_b`=0. The next contention grants requester 0.
- **Stats:** with `PFA32_SCHED_STATS_EN` and CNT_W=2, 5 accepts from req0 → `cnt0` reads 1,2,3,3,3 and `cnt1`=0. Without the macro, both counters stay 0.
